div3_stream_tx: RTL and testbench
=================================

Name: div3_stream_tx

Overview:
- Serial transmitter feeding the team's mod-3 stream checkers (MSB-first, one bit per clock).
- Accepts a parallel word through a valid/ready handshake and optionally multiplies it by 3, so the frame is a known multiple of 3.
- Shifts the frame out MSB-first over W+2 cycles.
- Tracks the running remainder mod 3 of the emitted bits and reports divisibility at frame end, giving an independent reference for checker verification.

Parameters:
- W, 8, input data width; legal W >= 2. Frame length L = W+2 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_mul3 valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W  unsigned word to transmit.
- in_mul3  input  1  1: frame = in_data*3; 0: frame = in_data zero-extended to W+2 bits.
- ser_out  output  1  current serial bit, MSB first.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_last  output  1  high with the final (LSB) bit of a frame.
- frame_done  output  1  one-cycle pulse the cycle after ser_last.
- frame_div3  output  1  valid when frame_done is high: 1 iff the emitted frame mod 3 == 0; holds its value otherwise.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, shift register=0, bit counter=0, rem=0. Outputs: ser_out=0, ser_valid=0, ser_last=0, frame_done=0, frame_div3=0. in_ready=1 once rst deasserts.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame bits being emitted.
- in_ready = (state==IDLE) OR (state==SHIFT AND bit counter == L-1). This allows zero-gap back-to-back frames.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - Frame F computed: in_mul3 ? (in_data<<1)+in_data : {2'b00,in_data}. Width is W+2; no overflow is possible since 3*(2^W-1) < 2^(W+2).
  - F loaded into the shift register; counter=0; rem=0; state=SHIFT.
- Latency: first bit (F[L-1]) appears on ser_out with ser_valid=1 in the cycle after accept.
- SHIFT: each cycle emits one bit:
  - ser_out = shift register MSB.
  - Register shifts left by one, filling with 0; counter increments.
  - ser_last=1 when counter==L-1.
  - All serial outputs are registered.
- Remainder update, on every edge where ser_valid=1: rem_next = (2*rem + ser_out) mod 3. Transition table:
  - rem0: bit 0 -> 0, bit 1 -> 1.
  - rem1: bit 0 -> 2, bit 1 -> 0.
  - rem2: bit 0 -> 1, bit 1 -> 2.
- Frame end, on the edge consuming the ser_last bit:
  - frame_done=1 for exactly one cycle.
  - frame_div3 = (rem_next==0).
  - If a new word is accepted on the same edge: rem restarts at 0, state stays SHIFT, the next frame's MSB is emitted the following cycle, and frame_done for the old frame still pulses.
  - Otherwise: state=IDLE, ser_valid=0, ser_out=0.
- Busy: in_valid while in_ready=0 is ignored. The input is not latched and no error is flagged; upstream must hold the word until ready.
- rst asserted mid-frame: immediate return to reset values; the frame is abandoned and frame_done is not pulsed.
- in_data/in_mul3 are sampled only at accept; later changes do not affect the frame in flight.
- No illegal states are reachable. An implementation with spare encodings must recover to IDLE.

Test Plan:
- W=8, in_data=0x05, in_mul3=1 -> ser_out over 10 cycles = 0000001111 (15); ser_last on 10th bit; next cycle frame_done=1, frame_div3=1.
- in_data=0x05, in_mul3=0 -> bits 0000000101; frame_div3=0 (5 mod 3 = 2).
- in_data=0xFF, in_mul3=1 -> bits 1011111101 (765); frame_div3=1; no overflow.
- Back-to-back: in_valid held high with 0x03/mul3=0 then 0x01/mul3=1.
  - Second accepted during the first frame's ser_last cycle; ser_valid stays high for 20 consecutive cycles.
  - First frame: frame_div3=1 (3). Second frame: frame_div3=1 (3).
- in_valid pulsed with 0xAA mid-frame (in_ready=0) -> ignored; emitted frame unchanged; only one frame_done.
- rst pulsed at bit 4 of a frame -> all outputs 0 immediately, no frame_done, in_ready=1 after release. The next word is transmitted correctly from its MSB.

Source files
------------

// File: rtl/div3_stream_tx_if.sv
// Handshake and serial-output bundle for div3_stream_tx.
// master: upstream producer / frame consumer side.
// slave : the transmitter itself.
interface div3_stream_tx_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mul3;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         frame_done;
  logic         frame_div3;

  modport master (
    output in_valid, in_data, in_mul3,
    input  in_ready, ser_out, ser_valid, ser_last, frame_done, frame_div3
  );

  modport slave (
    input  in_valid, in_data, in_mul3,
    output in_ready, ser_out, ser_valid, ser_last, frame_done, frame_div3
  );
endinterface

// File: rtl/div3_stream_tx.sv
// MSB-first serial transmitter of W+2-bit frames (word or word*3) that
// tracks the running remainder mod 3 of the emitted bits and reports
// divisibility one cycle after the last bit. All outputs are registered.
module div3_stream_tx #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  div3_stream_tx_if.slave bus
);

  localparam int L  = W + 2;
  localparam int CW = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // One step of the MSB-first mod-3 recurrence: (2*rem + b) mod 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic b);
    logic [1:0] r;
    case ({rem, b})
      3'b000:  r = 2'd0;
      3'b001:  r = 2'd1;
      3'b010:  r = 2'd2;
      3'b011:  r = 2'd0;
      3'b100:  r = 2'd1;
      3'b101:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [L-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     rem_q, rem_d;
  logic           ser_out_q, ser_out_d;
  logic           ser_valid_q, ser_valid_d;
  logic           ser_last_q, ser_last_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_div3_q, frame_div3_d;
  logic           in_ready_q, in_ready_d;

  logic           accept_s;
  logic [L-1:0]   frame_s;
  logic [L-1:0]   word_ext_s;
  logic [1:0]     rem_next_s;

  // Next-state logic: accept/load, bit emission, remainder tracking, frame end.
  always_comb begin
    accept_s   = bus.in_valid && in_ready_q;
    word_ext_s = {2'b00, bus.in_data};
    if (bus.in_mul3) begin
      frame_s = {word_ext_s[L-2:0], 1'b0} + word_ext_s;
    end else begin
      frame_s = word_ext_s;
    end
    rem_next_s = mod3_step(rem_q, ser_out_q);

    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    ser_last_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_div3_d = frame_div3_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_SHIFT;
          ser_out_d   = frame_s[L-1];
          ser_valid_d = 1'b1;
          sh_d        = {frame_s[L-2:0], 1'b0};
          cnt_d       = {CW{1'b0}};
          rem_d       = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) begin
          // Edge consuming the final bit: report, then reload or go idle.
          frame_done_d = 1'b1;
          frame_div3_d = (rem_next_s == 2'd0);
          if (accept_s) begin
            state_d     = ST_SHIFT;
            ser_out_d   = frame_s[L-1];
            ser_valid_d = 1'b1;
            sh_d        = {frame_s[L-2:0], 1'b0};
            cnt_d       = {CW{1'b0}};
            rem_d       = 2'd0;
          end else begin
            state_d = ST_IDLE;
            sh_d    = {L{1'b0}};
            cnt_d   = {CW{1'b0}};
            rem_d   = 2'd0;
          end
        end else begin
          ser_out_d   = sh_q[L-1];
          ser_valid_d = 1'b1;
          sh_d        = {sh_q[L-2:0], 1'b0};
          cnt_d       = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          ser_last_d  = (cnt_d == LAST);
          rem_d       = rem_next_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sh_d    = {L{1'b0}};
        cnt_d   = {CW{1'b0}};
        rem_d   = 2'd0;
      end
    endcase

    // Ready while idle or while the last bit of a frame is on the line.
    in_ready_d = (state_d == ST_IDLE) || (cnt_d == LAST);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sh_q         <= {L{1'b0}};
      cnt_q        <= {CW{1'b0}};
      rem_q        <= 2'd0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_div3_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      ser_last_q   <= ser_last_d;
      frame_done_q <= frame_done_d;
      frame_div3_q <= frame_div3_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_div3 = frame_div3_q;

endmodule

// File: tb/tb_div3_stream_tx.sv
// Directed bench for div3_stream_tx (W=8, 10-bit frames).
module tb_div3_stream_tx;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div3_stream_tx_if #(.W(8)) bus ();

  div3_stream_tx #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ser_out, bus.ser_valid, bus.ser_last, bus.frame_done, bus.frame_div3} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {bus.ser_out, bus.ser_valid, bus.ser_last, bus.frame_done, bus.frame_div3}, 5'b00000);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  // Three single frames from a table: 0x05*3, 0x05, 0xFF*3.
  task automatic test_single_frames();
    logic [7:0] d_t   [3];
    logic       m_t   [3];
    logic [9:0] e_t   [3];
    logic       div_t [3];
    logic [9:0] e;
    d_t[0] = 8'h05; m_t[0] = 1'b1; e_t[0] = 10'b0000001111; div_t[0] = 1'b1;
    d_t[1] = 8'h05; m_t[1] = 1'b0; e_t[1] = 10'b0000000101; div_t[1] = 1'b0;
    d_t[2] = 8'hFF; m_t[2] = 1'b1; e_t[2] = 10'b1011111101; div_t[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = e_t[k];
      bus.in_valid = 1'b1; bus.in_data = d_t[k]; bus.in_mul3 = m_t[k];
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL single%0d_ready got=%b exp=1", k, bus.in_ready);
      end
      cyc();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        checks++;
        if ({bus.ser_valid, bus.ser_out, bus.ser_last, bus.frame_done} !== {1'b1, e[9-i], (i == 9), 1'b0}) begin
          failures++;
          $display("FAIL single%0d_bit%0d got(v,o,l,d)=%b exp=%b", k, i,
                   {bus.ser_valid, bus.ser_out, bus.ser_last, bus.frame_done}, {1'b1, e[9-i], (i == 9), 1'b0});
        end
        cyc();
      end
      checks++;
      if ({bus.frame_done, bus.frame_div3, bus.ser_valid} !== {1'b1, div_t[k], 1'b0}) begin
        failures++;
        $display("FAIL single%0d_done got(d,div,v)=%b exp=%b", k,
                 {bus.frame_done, bus.frame_div3, bus.ser_valid}, {1'b1, div_t[k], 1'b0});
      end
      cyc();
      checks++;
      if ({bus.frame_done, bus.frame_div3} !== {1'b0, div_t[k]}) begin
        failures++;
        $display("FAIL single%0d_hold got(d,div)=%b exp=%b", k,
                 {bus.frame_done, bus.frame_div3}, {1'b0, div_t[k]});
      end
    end
  endtask

  // 0x03 then 0x01*3 with in_valid held: 20 contiguous bits.
  task automatic test_back_to_back();
    logic [19:0] e;
    e = {10'b0000000011, 10'b0000000011};
    bus.in_valid = 1'b1; bus.in_data = 8'h03; bus.in_mul3 = 1'b0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.ser_valid, bus.ser_out, bus.ser_last} !== {1'b1, e[19-i], (i == 9 || i == 19)}) begin
        failures++;
        $display("FAIL b2b_bit%0d got(v,o,l)=%b exp=%b", i,
                 {bus.ser_valid, bus.ser_out, bus.ser_last}, {1'b1, e[19-i], (i == 9 || i == 19)});
      end
      checks++;
      if ({bus.frame_done, bus.in_ready} !== {(i == 10), (i == 9 || i == 19)}) begin
        failures++;
        $display("FAIL b2b_ctl%0d got(done,ready)=%b exp=%b", i,
                 {bus.frame_done, bus.in_ready}, {(i == 10), (i == 9 || i == 19)});
      end
      if (i == 10) begin
        checks++;
        if (bus.frame_div3 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_div_first got=%b exp=1", bus.frame_div3);
        end
      end
      if (i == 9) begin
        bus.in_data = 8'h01; bus.in_mul3 = 1'b1;
      end
      if (i == 10) begin
        bus.in_valid = 1'b0;
      end
      cyc();
    end
    checks++;
    if ({bus.frame_done, bus.frame_div3, bus.ser_valid} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_done_second got(d,div,v)=%b exp=110",
               {bus.frame_done, bus.frame_div3, bus.ser_valid});
    end
    cyc();
  endtask

  // 0x07 frame with a 0xAA pulse while busy; the pulse must be ignored.
  task automatic test_busy_ignore();
    logic [9:0] e;
    int dones;
    e = 10'b0000000111;
    dones = 0;
    bus.in_valid = 1'b1; bus.in_data = 8'h07; bus.in_mul3 = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        checks++;
        if ({bus.ser_valid, bus.ser_out} !== {1'b1, e[9-i]}) begin
          failures++;
          $display("FAIL busy_bit%0d got(v,o)=%b exp=%b", i, {bus.ser_valid, bus.ser_out}, {1'b1, e[9-i]});
        end
      end else begin
        checks++;
        if (bus.ser_valid !== 1'b0) begin
          failures++;
          $display("FAIL busy_idle%0d ser_valid got=%b exp=0", i, bus.ser_valid);
        end
      end
      if (i == 10) begin
        checks++;
        if ({bus.frame_done, bus.frame_div3} !== 2'b10) begin
          failures++;
          $display("FAIL busy_done got(d,div)=%b exp=10", {bus.frame_done, bus.frame_div3});
        end
      end
      if (bus.frame_done === 1'b1) dones++;
      if (i == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_ready got=%b exp=0", bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_mul3 = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      cyc();
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL busy_done_count got=%0d exp=1", dones);
    end
  endtask

  // Reset at bit 4 of 0x10*3, then 0x04*3 must go out cleanly.
  task automatic test_rst_mid_frame();
    logic [9:0] e1;
    logic [9:0] e2;
    e1 = 10'b0000110000;
    e2 = 10'b0000001100;
    bus.in_valid = 1'b1; bus.in_data = 8'h10; bus.in_mul3 = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.ser_valid, bus.ser_out} !== {1'b1, e1[9-i]}) begin
        failures++;
        $display("FAIL rst_pre_bit%0d got(v,o)=%b exp=%b", i, {bus.ser_valid, bus.ser_out}, {1'b1, e1[9-i]});
      end
      cyc();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ser_out, bus.ser_valid, bus.ser_last, bus.frame_done, bus.frame_div3} !== 5'b00000) begin
      failures++;
      $display("FAIL rst_async_outputs got=%b exp=00000",
               {bus.ser_out, bus.ser_valid, bus.ser_last, bus.frame_done, bus.frame_div3});
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({bus.in_ready, bus.frame_done, bus.ser_valid} !== 3'b100) begin
        failures++;
        $display("FAIL rst_after%0d got(r,d,v)=%b exp=100", i, {bus.in_ready, bus.frame_done, bus.ser_valid});
      end
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h04; bus.in_mul3 = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.ser_valid, bus.ser_out, bus.ser_last} !== {1'b1, e2[9-i], (i == 9)}) begin
        failures++;
        $display("FAIL rst_next_bit%0d got(v,o,l)=%b exp=%b", i,
                 {bus.ser_valid, bus.ser_out, bus.ser_last}, {1'b1, e2[9-i], (i == 9)});
      end
      cyc();
    end
    checks++;
    if ({bus.frame_done, bus.frame_div3} !== 2'b11) begin
      failures++;
      $display("FAIL rst_next_done got(d,div)=%b exp=11", {bus.frame_done, bus.frame_div3});
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_mul3  = 1'b0;
    cyc();
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_busy_ignore();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
